// File: rtl/divisor_secuencial_pkg.sv
// Shared word format, derived dividend width and FSM state encoding for the
// sequential signed fixed-point divider.
package divisor_secuencial_pkg;

    localparam int N  = 16;
    localparam int F  = 8;
    localparam int W  = N + 1 + F;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CARGA  = 2'b01,
        DIVIDE = 2'b10,
        AJUSTE = 2'b11
    } estado_t;

endpackage

// File: rtl/divisor_secuencial_if.sv
// Start/done handshake and operand/result bus of the divider.
interface divisor_secuencial_if #(
    parameter int N = divisor_secuencial_pkg::N
);

    logic [N-1:0] dato1;
    logic [N-1:0] dato2;
    logic [N-1:0] dato3;
    logic         inicio;
    logic [N-1:0] resultado;
    logic         ocupado;
    logic         listo;
    logic         div_cero;
    logic         desborde;

    modport master (
        output dato1, dato2, dato3, inicio,
        input  resultado, ocupado, listo, div_cero, desborde
    );

    modport slave (
        input  dato1, dato2, dato3, inicio,
        output resultado, ocupado, listo, div_cero, desborde
    );

endinterface

// File: rtl/divisor_paso.sv
// One combinational restoring-division step: shift a bit into the remainder,
// trial-subtract the divisor, keep the difference only if it did not go negative.
module divisor_paso
    import divisor_secuencial_pkg::*;
(
    input  logic [N-1:0] resto,
    input  logic [N-1:0] divisor,
    input  logic         bit_entrada,
    output logic [N-1:0] resto_nuevo,
    output logic         q_bit
);

    logic [N:0]   desplazado;
    logic [N+1:0] diferencia;

    always_comb begin
        desplazado  = {resto, bit_entrada};
        diferencia  = {1'b0, desplazado} - {2'b00, divisor};
        q_bit       = ~diferencia[N+1];
        resto_nuevo = N'(q_bit ? diferencia[N:0] : desplazado);
    end

endmodule

// File: rtl/divisor_secuencial.sv
// Sequential signed Q(N-F).F divider recovering b = (r - c) / a, one restoring step per clock.
// Build option: DIVISOR_SATURACION_EN saturates the result on overflow instead of wrapping.
module divisor_secuencial
    import divisor_secuencial_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    divisor_secuencial_if.slave  bus
);

    localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-1){1'b0}}};
    localparam logic [W-1:0] MAX_POS = {{(W-N){1'b0}}, SAT_POS};
    localparam logic [W-1:0] MAX_NEG = {{(W-N){1'b0}}, SAT_NEG};

    estado_t estado, estado_sig;

    logic [N-1:0]  r_q, a_q, c_q;
    logic          signo, d_neg, d_cero;
    logic [N:0]    d_ext, d_mag;
    logic [N-1:0]  a_mag, resto, resto_nuevo;
    logic [W-1:0]  dividendo;
    logic [CW-1:0] cnt;
    logic          q_bit, ocupado_c, ovf_calc, cero_calc;
    logic [N-1:0]  res_calc, resultado_q;
    logic          listo_q, div_cero_q, desborde_q;

    divisor_paso u_paso (
        .resto       (resto),
        .divisor     (a_mag),
        .bit_entrada (dividendo[W-1]),
        .resto_nuevo (resto_nuevo),
        .q_bit       (q_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) estado <= IDLE;
        else        estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        ocupado_c  = 1'b0;
        case (estado)
            IDLE:   if (bus.inicio) estado_sig = CARGA;
            CARGA: begin
                ocupado_c  = 1'b1;
                estado_sig = cero_calc ? AJUSTE : DIVIDE;
            end
            DIVIDE: begin
                ocupado_c = 1'b1;
                if (cnt == CW'(W - 1)) estado_sig = AJUSTE;
            end
            AJUSTE: begin
                ocupado_c  = 1'b1;
                estado_sig = IDLE;
            end
            default: estado_sig = IDLE;
        endcase
    end

    // d is formed one bit wider than the operands so r - c can never wrap.
    always_comb begin
        d_ext     = {r_q[N-1], r_q} - {c_q[N-1], c_q};
        d_mag     = d_ext[N] ? -d_ext : d_ext;
        a_mag     = a_q[N-1] ? -a_q : a_q;
        cero_calc = (a_q == '0);
        ovf_calc  = signo ? (dividendo > MAX_NEG) : (dividendo > MAX_POS);
        res_calc  = signo ? N'(-dividendo) : dividendo[N-1:0];
        if (cero_calc) begin
            res_calc = d_cero ? '0 : (d_neg ? SAT_NEG : SAT_POS);
        end else if (ovf_calc) begin
`ifdef DIVISOR_SATURACION_EN
            res_calc = signo ? SAT_NEG : SAT_POS;
`endif
        end
    end

    // The dividend register shifts out its MSB each step and collects quotient bits at the LSB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q         <= '0;
            a_q         <= '0;
            c_q         <= '0;
            signo       <= 1'b0;
            d_neg       <= 1'b0;
            d_cero      <= 1'b0;
            dividendo   <= '0;
            resto       <= '0;
            cnt         <= '0;
            resultado_q <= '0;
            div_cero_q  <= 1'b0;
            desborde_q  <= 1'b0;
            listo_q     <= 1'b0;
        end else begin
            listo_q <= 1'b0;
            case (estado)
                IDLE: if (bus.inicio) begin
                    r_q <= bus.dato1;
                    a_q <= bus.dato2;
                    c_q <= bus.dato3;
                end
                CARGA: begin
                    signo     <= d_ext[N] ^ a_q[N-1];
                    d_neg     <= d_ext[N];
                    d_cero    <= (d_ext == '0);
                    dividendo <= {d_mag, {F{1'b0}}};
                    resto     <= '0;
                    cnt       <= '0;
                end
                DIVIDE: begin
                    resto     <= resto_nuevo;
                    dividendo <= {dividendo[W-2:0], q_bit};
                    cnt       <= cnt + 1'b1;
                end
                AJUSTE: begin
                    resultado_q <= res_calc;
                    div_cero_q  <= cero_calc;
                    desborde_q  <= !cero_calc && ovf_calc;
                    listo_q     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.resultado = resultado_q;
    assign bus.ocupado   = ocupado_c;
    assign bus.listo     = listo_q;
    assign bus.div_cero  = div_cero_q;
    assign bus.desborde  = desborde_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Directed self-checking bench for divisor_secuencial at N=16, F=8; expected values are hand-computed.
module tb_divisor_secuencial;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    divisor_secuencial_if bus ();

    divisor_secuencial dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef DIVISOR_SATURACION_EN
    localparam logic [15:0] OVF_POS  = 16'h7FFF;
    localparam logic [15:0] OVF_NEG  = 16'h8000;
    localparam logic [15:0] OVF_8000 = 16'h7FFF;
`else
    localparam logic [15:0] OVF_POS  = 16'hFE00;
    localparam logic [15:0] OVF_NEG  = 16'h0200;
    localparam logic [15:0] OVF_8000 = 16'h8000;
`endif

    typedef struct {
        string       name;
        logic [15:0] d1, d2, d3, res;
        logic        dz, ov;
        int          lat;
    } vec_t;

    // Drives one start pulse (sampled at the next edge) and waits, bounded, for listo.
    task automatic start_op(input logic [15:0] d1, d2, d3, output int lat, output logic busy);
        bus.dato1 = d1; bus.dato2 = d2; bus.dato3 = d3; bus.inicio = 1'b1;
        @(posedge clk); #1;
        bus.inicio = 1'b0;
        busy = bus.ocupado;
        lat = 0;
        while (!bus.listo && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (bus.resultado !== 16'h0000) begin miscompares++; $display("FAIL reset_resultado: got %h expected 0000", bus.resultado); end
        vectors++; if (bus.listo !== 1'b0) begin miscompares++; $display("FAIL reset_listo: got %b expected 0", bus.listo); end
        vectors++; if (bus.ocupado !== 1'b0) begin miscompares++; $display("FAIL reset_ocupado: got %b expected 0", bus.ocupado); end
        vectors++; if (bus.div_cero !== 1'b0) begin miscompares++; $display("FAIL reset_div_cero: got %b expected 0", bus.div_cero); end
        vectors++; if (bus.desborde !== 1'b0) begin miscompares++; $display("FAIL reset_desborde: got %b expected 0", bus.desborde); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        logic busy;
        start_op(16'h0700, 16'h0200, 16'h0100, lat, busy);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_ocupado: got %b expected 1", busy); end
        vectors++; if (lat !== 27) begin miscompares++; $display("FAIL basic_latency: got %0d expected 27", lat); end
        vectors++; if (bus.resultado !== 16'h0300) begin miscompares++; $display("FAIL basic_resultado: got %h expected 0300", bus.resultado); end
        vectors++; if ({bus.div_cero, bus.desborde} !== 2'b00) begin miscompares++; $display("FAIL basic_flags: got %b expected 00", {bus.div_cero, bus.desborde}); end
        repeat (5) @(posedge clk);
        #1;
        vectors++; if (bus.listo !== 1'b0) begin miscompares++; $display("FAIL basic_listo_pulse: got %b expected 0", bus.listo); end
        vectors++; if (bus.resultado !== 16'h0300) begin miscompares++; $display("FAIL basic_hold: got %h expected 0300", bus.resultado); end
        vectors++; if (bus.ocupado !== 1'b0) begin miscompares++; $display("FAIL basic_idle: got %b expected 0", bus.ocupado); end
    endtask

    task automatic test_arith();
        vec_t tbl[6] = '{
            '{"signed",        16'h0100, 16'h0200, 16'h0400, 16'hFE80,  1'b0, 1'b0, 27},
            '{"trunc_pos",     16'h0100, 16'h0300, 16'h0000, 16'h0055,  1'b0, 1'b0, 27},
            '{"trunc_neg",     16'hFF00, 16'h0300, 16'h0000, 16'hFFAB,  1'b0, 1'b0, 27},
            '{"ovf_pos",       16'h7F00, 16'h0080, 16'h0000, OVF_POS,   1'b0, 1'b1, 27},
            '{"ovf_neg",       16'h8100, 16'h0080, 16'h0000, OVF_NEG,   1'b0, 1'b1, 27},
            '{"ovf_pos_edge",  16'h4000, 16'h0100, 16'hC000, OVF_8000,  1'b0, 1'b1, 27}
        };
        int lat;
        logic busy;
        foreach (tbl[i]) begin
            start_op(tbl[i].d1, tbl[i].d2, tbl[i].d3, lat, busy);
            vectors++; if (lat !== tbl[i].lat) begin miscompares++; $display("FAIL %s_latency: got %0d expected %0d", tbl[i].name, lat, tbl[i].lat); end
            vectors++; if (bus.resultado !== tbl[i].res) begin miscompares++; $display("FAIL %s_resultado: got %h expected %h", tbl[i].name, bus.resultado, tbl[i].res); end
            vectors++; if (bus.div_cero !== tbl[i].dz) begin miscompares++; $display("FAIL %s_div_cero: got %b expected %b", tbl[i].name, bus.div_cero, tbl[i].dz); end
            vectors++; if (bus.desborde !== tbl[i].ov) begin miscompares++; $display("FAIL %s_desborde: got %b expected %b", tbl[i].name, bus.desborde, tbl[i].ov); end
        end
    endtask

    task automatic test_limits();
        // -128.0 / 1.0 gives exactly -2^15: representable, no overflow
        vec_t tbl[4] = '{
            '{"neg_edge",  16'h8000, 16'h0100, 16'h0000, 16'h8000, 1'b0, 1'b0, 27},
            '{"zero_pos",  16'h0200, 16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1'b0, 2},
            '{"zero_neg",  16'hFE00, 16'h0000, 16'h0000, 16'h8000, 1'b1, 1'b0, 2},
            '{"zero_zero", 16'h0300, 16'h0000, 16'h0300, 16'h0000, 1'b1, 1'b0, 2}
        };
        int lat;
        logic busy;
        foreach (tbl[i]) begin
            start_op(tbl[i].d1, tbl[i].d2, tbl[i].d3, lat, busy);
            vectors++; if (lat !== tbl[i].lat) begin miscompares++; $display("FAIL %s_latency: got %0d expected %0d", tbl[i].name, lat, tbl[i].lat); end
            vectors++; if (bus.resultado !== tbl[i].res) begin miscompares++; $display("FAIL %s_resultado: got %h expected %h", tbl[i].name, bus.resultado, tbl[i].res); end
            vectors++; if (bus.div_cero !== tbl[i].dz) begin miscompares++; $display("FAIL %s_div_cero: got %b expected %b", tbl[i].name, bus.div_cero, tbl[i].dz); end
            vectors++; if (bus.desborde !== tbl[i].ov) begin miscompares++; $display("FAIL %s_desborde: got %b expected %b", tbl[i].name, bus.desborde, tbl[i].ov); end
        end
    endtask

    task automatic test_inicio_ignored();
        int lat;
        int extra;
        bus.dato1 = 16'h0700; bus.dato2 = 16'h0200; bus.dato3 = 16'h0100; bus.inicio = 1'b1;
        @(posedge clk); #1;
        bus.inicio = 1'b0;
        lat = 0;
        while (!bus.listo && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 10) begin
                bus.dato1 = 16'h1200; bus.dato2 = 16'h0000; bus.inicio = 1'b1;
            end else begin
                bus.inicio = 1'b0;
            end
        end
        bus.inicio = 1'b0;
        vectors++; if (lat !== 27) begin miscompares++; $display("FAIL ignored_latency: got %0d expected 27", lat); end
        vectors++; if (bus.resultado !== 16'h0300) begin miscompares++; $display("FAIL ignored_resultado: got %h expected 0300", bus.resultado); end
        vectors++; if (bus.div_cero !== 1'b0) begin miscompares++; $display("FAIL ignored_div_cero: got %b expected 0", bus.div_cero); end
        extra = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.listo) extra++;
        end
        vectors++; if (extra !== 0) begin miscompares++; $display("FAIL ignored_no_restart: got %0d listo pulses expected 0", extra); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic busy;
        start_op(16'h0100, 16'h0200, 16'h0400, lat, busy);
        vectors++; if (bus.resultado !== 16'hFE80) begin miscompares++; $display("FAIL b2b_first: got %h expected fe80", bus.resultado); end
        start_op(16'h0700, 16'h0200, 16'h0100, lat, busy);
        vectors++; if (lat !== 27) begin miscompares++; $display("FAIL b2b_latency: got %0d expected 27", lat); end
        vectors++; if (bus.resultado !== 16'h0300) begin miscompares++; $display("FAIL b2b_second: got %h expected 0300", bus.resultado); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        logic busy;
        bus.dato1 = 16'h0100; bus.dato2 = 16'h0300; bus.dato3 = 16'h0000; bus.inicio = 1'b1;
        @(posedge clk); #1;
        bus.inicio = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        vectors++; if (bus.resultado !== 16'h0000) begin miscompares++; $display("FAIL midreset_resultado: got %h expected 0000", bus.resultado); end
        vectors++; if (bus.ocupado !== 1'b0) begin miscompares++; $display("FAIL midreset_ocupado: got %b expected 0", bus.ocupado); end
        vectors++; if ({bus.listo, bus.div_cero, bus.desborde} !== 3'b000) begin miscompares++; $display("FAIL midreset_flags: got %b expected 000", {bus.listo, bus.div_cero, bus.desborde}); end
        @(posedge clk); #1;
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.listo || bus.ocupado) seen++;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL midreset_aborted: got %0d active cycles expected 0", seen); end
        start_op(16'h0700, 16'h0200, 16'h0100, lat, busy);
        vectors++; if (lat !== 27) begin miscompares++; $display("FAIL postreset_latency: got %0d expected 27", lat); end
        vectors++; if (bus.resultado !== 16'h0300) begin miscompares++; $display("FAIL postreset_resultado: got %h expected 0300", bus.resultado); end
    endtask

    initial begin
        bus.dato1 = '0; bus.dato2 = '0; bus.dato3 = '0; bus.inicio = 1'b0;
        test_reset();
        test_basic();
        test_arith();
        test_limits();
        test_inicio_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/divisor_secuencial.md
# divisor_secuencial

Multi-cycle signed fixed-point divider that inverts the multiply-add datapath: given a result `r = a*b + c`, it recovers `b = (r - c) / a`. It uses one restoring-division step per clock, with a start/done handshake, saturation and flags. It sits beside the arithmetic unit and uses the same Q(N-F).F two's-complement word format.

## Interface
- `N`, default 16: word width, taken from `constantes.h`.
- `F`, default 8: fractional bits, taken from `constantes.h`.
- `clk` input 1: clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `dato1` input N: r, signed Q format.
- `dato2` input N: a (divisor), signed Q format.
- `dato3` input N: c (offset), signed Q format.
- `inicio` input 1: start request, sampled only in IDLE.
- `resultado` output N: b, signed Q format; holds its value until the next `listo`.
- `ocupado` output 1: high while an operation is in progress.
- `listo` output 1: one-cycle pulse when `resultado` and the flags update.
- `div_cero` output 1: last operation had `dato2 == 0`.
- `desborde` output 1: last quotient exceeded the signed N-bit range.

## Operation
- Internal dividend width W = N+1+F (25 at the defaults).
- States: IDLE, CARGA, DIVIDE, AJUSTE.
- **IDLE**
  - On `inicio`=1, register `dato1`, `dato2`, `dato3` and go to CARGA.
  - `inicio` in any other state is ignored.
- **CARGA**
  - d = dato1 - dato3 in N+1 signed bits, so there is no wrap.
  - Compute sign = sign(d) XOR sign(dato2).
  - Compute |d| (N+1 bits) and |dato2| (N bits).
  - Dividend = |d| << F (W bits). Remainder and iteration counter are cleared.
  - If dato2 == 0, go directly to AJUSTE; otherwise go to DIVIDE.
- **DIVIDE**
  - Exactly W iterations, MSB first, one per cycle.
  - Each iteration: shift the remainder in, trial-subtract |dato2|, set the quotient bit, restore if the subtraction went negative.
  - Then go to AJUSTE.
- **AJUSTE**
  - Quotient magnitude Q (W bits), truncated toward zero.
  - Signed result = sign ? -Q : Q.
  - Overflow when Q > 2^(N-1)-1 with a positive sign, or Q > 2^(N-1) with a negative sign. Overflow sets `desborde`.
  - Division by zero:
    - `div_cero`=1 and `desborde`=0.
    - `resultado` = 0x7FFF if d > 0, 0x8000 if d < 0, 0 if d == 0 (N=16 values).
  - Register `resultado` and the flags, pulse `listo`, return to IDLE.
- `ocupado` = 1 in CARGA, DIVIDE and AJUSTE.
- Reset:
  - All outputs go to 0 and the state goes to IDLE.
  - Reset mid-operation aborts it with no `listo`; the next operation needs a new `inicio`.

## Timing
- `inicio` is sampled at edge k.
- Normal latency: `listo` is high in the cycle following edge k+W+2 (k+27 at the defaults).
- Divide-by-zero latency: `listo` follows edge k+2.
- `inicio` held high during `listo` starts a new operation only when it is sampled in IDLE. The earliest restart is the edge after `listo`.
- `resultado`, `div_cero` and `desborde` change only on the edge that raises `listo`.

## Configuration
- `DIVISOR_SATURACION_EN` defined:
  - On overflow, `resultado` = 2^(N-1)-1 (positive) or -2^(N-1) (negative).
- Undefined:
  - On overflow, `resultado` = the low N bits of the signed quotient (wrap).
- `desborde` is set on overflow in both cases.

## Structure
- `constantes.h` holds:
  - N and F.
  - The state encodings (2 bits).
  - W, derived as N+1+F.
- Sub-module `divisor_paso`: one combinational restoring step.
  - Inputs: remainder, divisor, incoming bit.
  - Outputs: new remainder, quotient bit.
  - Instantiated once; the FSM iterates it across cycles.

## Test plan
All values at N=16, F=8.

1. Basic: dato1=0x0700, dato2=0x0200, dato3=0x0100 -> `resultado`=0x0300, flags 0, `listo` exactly 27 cycles after `inicio`.
2. Signed: dato1=0x0100, dato2=0x0200, dato3=0x0400 -> 0xFE80 (-1.5).
3. Truncation toward zero:
   - dato1=0x0100, dato2=0x0300, dato3=0 -> 0x0055.
   - dato1=0xFF00, same dato2 and dato3 -> 0xFFAB.
4. Zero divisor: dato2=0, dato1=0x0200, dato3=0 -> 0x7FFF, `div_cero`=1, `listo` 2 cycles after `inicio`.
5. Overflow: dato1=0x7F00, dato2=0x0080, dato3=0 -> `desborde`=1; `resultado`=0x7FFF with the macro, 0xFE00 without.
6. Control:
   - `inicio` pulsed mid-DIVIDE is ignored and the result is unchanged.
   - `reset` low at cycle 10 -> no `listo`, all outputs 0.
   - A new `inicio` after reset gives the correct result.
